// File: rtl/fsm_3lnpp_sched.sv
// Three-level (Z/P/N) leg level scheduler: settle/dwell timing per commutation, P<->N bridged through Z.
// Optional macro FAULT_TRIP_EN adds a TRIP state that forces Z until fault_clr.
`ifndef TDELAY_WIDTH
`define TDELAY_WIDTH 8
`endif

module fsm_3lnpp_sched #(
  parameter int TDW = `TDELAY_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [TDW-1:0] t_settle,
  input  logic [TDW-1:0] t_dwell,
  input  logic [1:0]     lev_req,
  input  logic           lev_req_valid,
  output logic           lev_req_ready,
  output logic [1:0]     v_lev,
  output logic           busy,
  output logic [15:0]    comm_cnt,
  input  logic           fault,
  input  logic           fault_clr,
  output logic           tripped,
  output logic [1:0]     state_dbg
);

  // Handshake: lev_req is taken on any clock edge where lev_req_valid && lev_req_ready;
  // the requester holds lev_req stable while valid is high and ready is low.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DWELL  = 2'd2,
    TRIP   = 2'd3
  } state_t;

  localparam logic [1:0] LZ = 2'b00;
  localparam logic [1:0] LX = 2'b11;

  state_t         state;
  logic           bridge_pend;
  logic [1:0]     target;
  logic [TDW-1:0] cnt;
  logic           last_cycle;
  logic           leg_done;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // A leg ends on the last SETTLE cycle when no dwell follows, or on the last DWELL cycle.
  assign last_cycle = (cnt <= TDW'(1));
  assign leg_done   = last_cycle &&
                      (((state == SETTLE) && (t_dwell == '0)) || (state == DWELL));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      v_lev       <= LZ;
      bridge_pend <= 1'b0;
      target      <= LZ;
      cnt         <= '0;
      comm_cnt    <= '0;
    end
`ifdef FAULT_TRIP_EN
    else if (fault) begin
      state       <= TRIP;
      v_lev       <= LZ;
      bridge_pend <= 1'b0;
      cnt         <= '0;
      if (v_lev != LZ) comm_cnt <= sat_inc(comm_cnt);
    end
`endif
    else begin
      case (state)
        IDLE: begin
          if (lev_req_valid && lev_req != LX && lev_req != v_lev) begin
            cnt      <= t_settle;
            state    <= SETTLE;
            comm_cnt <= sat_inc(comm_cnt);
            if (v_lev == LZ || lev_req == LZ) begin
              v_lev <= lev_req;
            end else begin
              v_lev       <= LZ;
              target      <= lev_req;
              bridge_pend <= 1'b1;
            end
          end
        end
        SETTLE: begin
          if (!last_cycle) begin
            cnt <= cnt - TDW'(1);
          end else if (t_dwell != '0) begin
            cnt   <= t_dwell;
            state <= DWELL;
          end
        end
        DWELL: begin
          if (!last_cycle) cnt <= cnt - TDW'(1);
        end
        TRIP: begin
`ifdef FAULT_TRIP_EN
          if (fault_clr) state <= IDLE;
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase

      // Second half of a bridge is issued without a new handshake.
      if (leg_done) begin
        if (bridge_pend) begin
          v_lev       <= target;
          bridge_pend <= 1'b0;
          cnt         <= t_settle;
          state       <= SETTLE;
          comm_cnt    <= sat_inc(comm_cnt);
        end else begin
          state <= IDLE;
        end
      end
    end
  end

  assign lev_req_ready = (state == IDLE) && !bridge_pend;
  assign busy          = (state == SETTLE);
  assign state_dbg     = state;

`ifdef FAULT_TRIP_EN
  assign tripped = (state == TRIP);
`else
  logic unused_fault;
  assign unused_fault = fault | fault_clr;
  assign tripped      = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_3lnpp_sched.sv
// Scoreboard bench for fsm_3lnpp_sched: driver pushes expected v_lev events, a monitor pops on each change.
// Fault scenarios are included when FAULT_TRIP_EN is defined.
module tb_fsm_3lnpp_sched;
  localparam int TDW = 8;
  localparam int EW  = 50;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [TDW-1:0] t_settle = '0;
  logic [TDW-1:0] t_dwell = '0;
  logic [1:0]     lev_req = '0;
  logic           lev_req_valid = 1'b0;
  logic           lev_req_ready;
  logic [1:0]     v_lev;
  logic           busy;
  logic [15:0]    comm_cnt;
  logic           fault = 1'b0;
  logic           fault_clr = 1'b0;
  logic           tripped;
  logic [1:0]     state_dbg;

  fsm_3lnpp_sched #(.TDW(TDW)) dut (
    .clk(clk), .rst(rst), .t_settle(t_settle), .t_dwell(t_dwell),
    .lev_req(lev_req), .lev_req_valid(lev_req_valid), .lev_req_ready(lev_req_ready),
    .v_lev(v_lev), .busy(busy), .comm_cnt(comm_cnt), .fault(fault),
    .fault_clr(fault_clr), .tripped(tripped), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  bit          mon_en = 1'b0;
  logic [1:0]  prev_v;
  logic [1:0]  model_lev = 2'b00;
  int          model_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [EW-1:0] pk(input logic [31:0] c, input logic [1:0] v, input int n);
    return {c, v, 16'(n)};
  endfunction

  function automatic int inc_sat(input int n);
    return (n < 65535) ? n + 1 : n;
  endfunction

  // monitor: every v_lev change must match the head of the expected queue
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_v = v_lev;
    end else begin
      if (v_lev !== prev_v) begin
        check("no_direct_pn",
              64'((prev_v == 2'b01 && v_lev == 2'b10) || (prev_v == 2'b10 && v_lev == 2'b01)), 64'd0);
        if (exp_q.size() == 0) check("spurious_vlev_change", 64'(v_lev), 64'(prev_v));
        else check("vlev_event", 64'({cyc, v_lev, comm_cnt}), 64'(exp_q.pop_front()));
        prev_v = v_lev;
      end
      if (exp_q.size() > 0) begin
        if (exp_q[0][49:18] < cyc) begin
          check("missed_event_cycle", 64'(cyc), 64'(exp_q[0][49:18]));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // driver: issue one request, model its outcome, then wait for ready to return
  task automatic issue(input logic [1:0] req, input int ts, input int td);
    logic [31:0] acc;
    int lat, busy_n, leg, exp_lat, exp_busy;
    bit nop, bridge;
    check("ready_before_req", 64'(lev_req_ready), 64'd1);
    t_settle = TDW'(ts);
    t_dwell = TDW'(td);
    lev_req = req;
    lev_req_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    lev_req_valid = 1'b0;
    leg = ((ts < 1) ? 1 : ts) + td;
    nop = (req == 2'b11) || (req == model_lev);
    bridge = !nop && (model_lev != 2'b00) && (req != 2'b00);
    if (!nop) begin
      if (bridge) begin
        model_cnt = inc_sat(model_cnt);
        exp_q.push_back(pk(acc, 2'b00, model_cnt));
        model_cnt = inc_sat(model_cnt);
        exp_q.push_back(pk(acc + 32'(leg), req, model_cnt));
      end else begin
        model_cnt = inc_sat(model_cnt);
        exp_q.push_back(pk(acc, req, model_cnt));
      end
      model_lev = req;
    end
    // t_settle was captured at accept; moving it now must not disturb the running interval
    if (!bridge) t_settle = TDW'($urandom_range(0, 15));
    exp_lat  = nop ? 0 : (bridge ? 2 * leg : leg);
    exp_busy = nop ? 0 : ((bridge ? 2 : 1) * ((ts < 1) ? 1 : ts));
    lat = 0;
    busy_n = 0;
    @(negedge clk);
    while (!lev_req_ready && lat < 400) begin
      if (busy) busy_n++;
      lat++;
      @(negedge clk);
    end
    check("ready_latency", 64'(lat), 64'(exp_lat));
    check("busy_cycles", 64'(busy_n), 64'(exp_busy));
    check("vlev_after", 64'(v_lev), 64'(model_lev));
    check("comm_cnt_after", 64'(comm_cnt), 64'(model_cnt));
  endtask

  initial begin
    logic [31:0] acc;
    #1_000_000;
    $display("FAIL watchdog expired actual=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] acc;
    logic [31:0] r;
    repeat (3) @(negedge clk);
    check("rst_vlev", 64'(v_lev), 64'd0);
    check("rst_comm_cnt", 64'(comm_cnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tripped", 64'(tripped), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(lev_req_ready), 64'd1);
    mon_en = 1'b1;

    // directed: adjacent, bridge, no-op, zero timing
    issue(2'b01, 3, 2);
    issue(2'b10, 3, 2);
    issue(2'b10, 3, 2);
    issue(2'b11, 3, 2);
    issue(2'b00, 1, 0);
    issue(2'b01, 0, 0);
    issue(2'b10, 0, 1);

    // randomized requests and timings
    for (int i = 0; i < 40; i++)
      issue(2'($urandom_range(0, 3)), $urandom_range(0, 4), $urandom_range(0, 3));

    // reset in DWELL at N
    issue(2'b00, 1, 0);
    t_settle = TDW'(2);
    t_dwell = TDW'(4);
    lev_req = 2'b10;
    lev_req_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    lev_req_valid = 1'b0;
    model_cnt = inc_sat(model_cnt);
    exp_q.push_back(pk(acc, 2'b10, model_cnt));
    repeat (4) @(negedge clk);
    check("in_dwell_busy", 64'(busy), 64'd0);
    check("in_dwell_ready", 64'(lev_req_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    r = cyc;
    rst = 1'b0;
    model_cnt = 0;
    model_lev = 2'b00;
    exp_q.push_back(pk(r, 2'b00, 0));
    @(negedge clk);
    check("midrst_vlev", 64'(v_lev), 64'd0);
    check("midrst_comm_cnt", 64'(comm_cnt), 64'd0);
    check("midrst_ready", 64'(lev_req_ready), 64'd1);
    repeat (8) @(negedge clk);
    check("midrst_no_target", 64'(v_lev), 64'd0);
    issue(2'b01, 2, 1);

`ifdef FAULT_TRIP_EN
    // fault during the Z phase of a P->N bridge
    t_settle = TDW'(3);
    t_dwell = TDW'(2);
    lev_req = 2'b10;
    lev_req_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    lev_req_valid = 1'b0;
    model_cnt = inc_sat(model_cnt);
    exp_q.push_back(pk(acc, 2'b00, model_cnt));
    model_lev = 2'b00;
    repeat (2) @(negedge clk);
    fault = 1'b1;
    @(posedge clk);
    #1;
    fault = 1'b0;
    @(negedge clk);
    check("trip_tripped", 64'(tripped), 64'd1);
    check("trip_vlev", 64'(v_lev), 64'd0);
    check("trip_ready", 64'(lev_req_ready), 64'd0);
    fault = 1'b1;
    fault_clr = 1'b1;
    @(posedge clk);
    #1;
    fault = 1'b0;
    fault_clr = 1'b0;
    @(negedge clk);
    check("trip_fault_wins", 64'(tripped), 64'd1);
    fault_clr = 1'b1;
    @(posedge clk);
    #1;
    fault_clr = 1'b0;
    @(negedge clk);
    check("trip_cleared", 64'(tripped), 64'd0);
    check("trip_clr_ready", 64'(lev_req_ready), 64'd1);
    repeat (12) @(negedge clk);
    check("trip_no_n_issued", 64'(v_lev), 64'd0);
    check("trip_comm_cnt", 64'(comm_cnt), 64'(model_cnt));
    issue(2'b10, 1, 1);
`endif

    repeat (2) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
